// File: rtl/seq_fail_monitor.sv
//==============================================================================
// Module   : seq_fail_monitor
// Purpose  : Checks that "in1 followed one cycle later by in2" never occurs.
//            Outputs saturating pass/fail counters, sticky flags and a
//            timestamped failure FIFO.
// Revision : 1.0
//==============================================================================
`default_nettype none

module seq_fail_monitor #(
    parameter int CW    = 16,
    parameter int TW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dis,
    input  logic          in1,
    input  logic          in2,
    input  logic          clear,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          fail_flag,
    output logic          fail_pulse,
    output logic          fail_valid,
    output logic [TW-1:0] fail_time,
    input  logic          fail_ready,
    output logic          ovf
);

    localparam int C_AW = $clog2(DEPTH);

    logic            r_pend;
    logic [TW-1:0]   r_ts;
    logic [TW-1:0]   r_mem [DEPTH];
    logic [C_AW:0]   r_wr_ptr;
    logic [C_AW:0]   r_rd_ptr;

    logic            w_pend_live;
    logic            w_fail;
    logic            w_pass_old;
    logic            w_pass_new;
    logic [1:0]      w_pass_add;
    logic [CW:0]     w_pass_sum;
    logic [CW:0]     w_fail_sum;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    // Resolution of the attempt started on the previous edge, then the new one.
    assign w_pend_live = r_pend & ~dis;
    assign w_fail      = w_pend_live & in2;
    assign w_pass_old  = w_pend_live & ~in2;
    assign w_pass_new  = ~dis & ~in1;
    assign w_pass_add  = {1'b0, w_pass_old} + {1'b0, w_pass_new};

    // One extra bit catches overflow so both +1 and +2 saturate cleanly.
    assign w_pass_sum  = {1'b0, pass_cnt} + {{(CW-1){1'b0}}, w_pass_add};
    assign w_fail_sum  = {1'b0, fail_cnt} + {{CW{1'b0}}, w_fail};

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                         (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign fail_valid  = ~w_empty;
    assign w_pop       = fail_valid & fail_ready;
    assign w_push      = w_fail & (~w_full | w_pop);
    assign fail_time   = fail_valid ? r_mem[r_rd_ptr[C_AW-1:0]] : '0;

    // Free-running timestamp; clear deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_flag  <= 1'b0;
            fail_pulse <= 1'b0;
            ovf        <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (clear) begin
            r_pend     <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_flag  <= 1'b0;
            fail_pulse <= 1'b0;
            ovf        <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_pend     <= ~dis & in1;
            fail_pulse <= w_fail;
            pass_cnt   <= w_pass_sum[CW] ? {CW{1'b1}} : w_pass_sum[CW-1:0];
            fail_cnt   <= w_fail_sum[CW] ? {CW{1'b1}} : w_fail_sum[CW-1:0];
            if (w_fail) begin
                fail_flag <= 1'b1;
            end
            if (w_fail && w_full && !w_pop) begin
                ovf <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= r_ts;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_fail_monitor.sv
//==============================================================================
// Module   : tb_seq_fail_monitor
// Purpose  : Self-checking bench for seq_fail_monitor against a queue model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_seq_fail_monitor;

    localparam int CW    = 4;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          dis;
    logic          in1;
    logic          in2;
    logic          clear;
    logic          fail_ready;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          fail_flag;
    logic          fail_pulse;
    logic          fail_valid;
    logic [TW-1:0] fail_time;
    logic          ovf;

    seq_fail_monitor #(.CW(CW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .dis        (dis),
        .in1        (in1),
        .in2        (in2),
        .clear      (clear),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .fail_flag  (fail_flag),
        .fail_pulse (fail_pulse),
        .fail_valid (fail_valid),
        .fail_time  (fail_time),
        .fail_ready (fail_ready),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: counts, flags, a queue of failure timestamps.
    int m_pass;
    int m_fail;
    bit m_flag;
    bit m_pulse;
    bit m_ovf;
    bit m_pend;
    int m_ts;
    int q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pass_cnt"},   32'(pass_cnt),   32'(m_pass));
        chk({tag, ".fail_cnt"},   32'(fail_cnt),   32'(m_fail));
        chk({tag, ".fail_flag"},  32'(fail_flag),  32'(m_flag));
        chk({tag, ".fail_pulse"}, 32'(fail_pulse), 32'(m_pulse));
        chk({tag, ".fail_valid"}, 32'(fail_valid), 32'(q.size() > 0));
        chk({tag, ".fail_time"},  32'(fail_time),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
    endtask

    task automatic model_reset();
        m_pass = 0; m_fail = 0; m_flag = 0; m_pulse = 0;
        m_ovf = 0; m_pend = 0; m_ts = 0;
        q.delete();
    endtask

    task automatic model_edge();
        int  p;
        bit  f;
        bit  pop;
        p   = 0;
        f   = 0;
        pop = (q.size() > 0) && fail_ready;
        if (clear) begin
            m_pass = 0; m_fail = 0; m_flag = 0; m_pulse = 0;
            m_ovf = 0; m_pend = 0;
            q.delete();
        end else begin
            if (m_pend && !dis) begin
                if (in2) f = 1;
                else     p++;
            end
            if (!dis && !in1) p++;
            m_pend = !dis && in1;
            m_pass = (m_pass + p > MAXC) ? MAXC : m_pass + p;
            if (f) begin
                m_fail = (m_fail + 1 > MAXC) ? MAXC : m_fail + 1;
                m_flag = 1;
            end
            if (pop) void'(q.pop_front());
            if (f) begin
                if (q.size() < DEPTH) q.push_back(m_ts);
                else                  m_ovf = 1;
            end
            m_pulse = f;
        end
        m_ts = (m_ts + 1) % (1 << TW);
    endtask

    task automatic step(input bit d, input bit a, input bit b, input bit c,
                        input bit r, input string tag);
        dis = d; in1 = a; in2 = b; clear = c; fail_ready = r;
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; dis = 1'b0; in1 = 1'b0; in2 = 1'b0;
        clear = 1'b0; fail_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, "vacuous");
        chk("vac10.pass_cnt", 32'(pass_cnt), 32'd10);

        // in1 at ts=10, in2 at ts=11: failure stamped 11
        step(0, 1, 0, 0, 0, "seq_in1");
        step(0, 0, 1, 0, 0, "seq_in2");
        chk("seq.fail_pulse", 32'(fail_pulse), 32'd1);
        chk("seq.fail_time",  32'(fail_time),  32'd11);
        chk("seq.pass_cnt",   32'(pass_cnt),   32'd11);
        step(0, 0, 0, 0, 0, "seq_after");

        step(0, 1, 0, 0, 0, "dis_in1");
        step(1, 0, 1, 0, 0, "dis_abort");
        chk("dis.fail_cnt", 32'(fail_cnt), 32'd1);

        step(0, 0, 0, 0, 1, "pop_one");
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, "fill");
        chk("fill.ovf", 32'(ovf), 32'd1);
        chk("fill.fail_cnt", 32'(fail_cnt), 32'd7);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, "drain");
        chk("drain.fail_valid", 32'(fail_valid), 32'd0);

        step(0, 0, 0, 1, 0, "clear1");
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, "sat");
        chk("sat.pass_cnt", 32'(pass_cnt), 32'(MAXC));
        step(0, 0, 0, 1, 0, "clear2");
        chk("clear.pass_cnt", 32'(pass_cnt), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) == 0, $urandom % 2, $urandom % 2,
                 ($urandom % 32) == 0, $urandom % 2, "random");
        end

        step(0, 1, 0, 0, 0, "alt1");
        step(0, 0, 0, 0, 0, "alt2");
        step(0, 1, 1, 0, 0, "alt3");
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, "post_rst");
        chk("post_rst.fail_cnt", 32'(fail_cnt), 32'd0);
        for (int i = 0; i < 100; i++) begin
            step(($urandom % 8) == 0, $urandom % 2, $urandom % 2,
                 ($urandom % 40) == 0, ($urandom % 4) != 0, "random2");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_fail_monitor.md
# seq_fail_monitor

Synthesizable checker for the property "in1 followed one clock later by in2 must never occur", with a synchronous disable input. It sits downstream of the stimulus and DUT signal pair. Each attempt is resolved in hardware as pass, fail or disabled. Results are accumulated in saturating counters, a sticky fail flag and a timestamped failure FIFO that a log/CSR stage drains over a valid/ready handshake.

## Interface
- CW, 16, width of the pass and fail counters (saturating)
- TW, 32, width of the free-running cycle timestamp
- DEPTH, 4, failure FIFO entries (power of two, at least 2)
- clk  input  1  sampling clock, all logic on posedge
- rst  input  1  asynchronous active-high reset; async assert, sync release
- dis  input  1  disable: aborts any attempt it overlaps
- in1  input  1  antecedent (first sequence element)
- in2  input  1  second sequence element, checked one cycle after in1
- clear  input  1  synchronous clear of counters, flags and FIFO
- pass_cnt  output  CW  number of passed attempts
- fail_cnt  output  CW  number of failed attempts
- fail_flag  output  1  sticky: at least one failure since reset/clear
- fail_pulse  output  1  high for one cycle after each edge that produced a failure
- fail_valid  output  1  FIFO head valid
- fail_time  output  TW  timestamp of FIFO head failure
- fail_ready  input  1  consumer accepts head when fail_valid && fail_ready
- ovf  output  1  sticky: a failure was dropped because the FIFO was full

## Operation
- One attempt starts at every posedge k, sampling dis, in1 and in2 at that edge.
- Internal register pend marks an attempt started at k-1 that is awaiting in2.
- Resolution at edge k, pending attempt (pend=1):
  - dis=1: disabled, no count.
  - else in2=1: fail.
  - else: pass.
- Resolution at edge k, new attempt:
  - dis=1: disabled.
  - else in1=0: vacuous pass.
  - else: pend is set for the next edge.
- Both resolutions can occur at one edge, giving 0, 1 or 2 passes, or 1 pass plus 1 fail.
- pass_cnt adds the 0..2 passes and saturates at 2^CW-1. Adding 2 at 2^CW-2 also saturates.
- fail_cnt adds 1 per fail and saturates.
- ts is a TW-bit counter that increments every cycle, wraps to 0 and is unaffected by clear.
- A failure at edge k records the ts value sampled at edge k.
- FIFO push on fail:
  - Full with no pop this cycle: entry dropped, ovf set, fail_cnt still increments.
  - Full with a pop this cycle: push succeeds.
- Pop occurs when fail_valid && fail_ready. fail_time is stable while fail_valid && !fail_ready.
- clear=1 at edge k:
  - Zeroes pass_cnt, fail_cnt, fail_flag, ovf, pend and the FIFO.
  - Discards all resolutions at k. No fail_pulse.
  - Takes priority over push and pop.
- Reset values: all outputs 0, pend=0, ts=0, FIFO empty.
- Reset mid-attempt clears pend; that attempt is never counted.

## Timing
- Results of edge k are visible from just after edge k: counters, fail_flag, fail_pulse, fail_valid and fail_time.
- Latency from in2 sampled to fail_pulse and fail_valid is one edge, with no bubble.
- FIFO is registered and first-word-fall-through. An entry pushed at edge k is poppable at edge k+1.
- Full throughput is one pop per cycle.
- The first attempt after reset release starts at the first posedge with rst=0.

## Test plan
- Reset, then in1=0 for 10 cycles -> pass_cnt=10, fail_cnt=0, fail_valid=0.
- At ts=5: in1=1, then in2=1 at the next edge -> fail_pulse one cycle, fail_cnt=1, fail_flag=1, fail_time=6. pass_cnt counts only the vacuous passes.
- in1=1 at edge k, dis=1 at edge k+1 with in2=1 -> no fail, attempt k not counted, attempt k+1 disabled.
- fail_ready=0 and 6 failures with DEPTH=4 -> 4 entries held, ovf=1, fail_cnt=6. Drain with fail_ready=1 -> 4 timestamps in order, then fail_valid=0.
- CW=4, in1=0 for 20 cycles -> pass_cnt holds 15. clear then yields 0, while ts keeps counting.
- in1=1 with in2=0 on alternating edges, then rst pulsed mid-pend -> all outputs 0 immediately, no late pass or fail after release.
